// File: rtl/linebuf_window_ctrl.sv
// ---------------------------------------------------------------------------
// linebuf_window_ctrl
//
// Sequencer for the two cascaded line-buffer FIFOs that sit in front of the
// 3x3 image-filter window. It gates the raw pixel stream into the line-buffer
// chain, clears the buffers at every frame start, and tracks the column/row
// position. When a full 3x3 window is available it emits a pulse with the
// window's centre coordinate. It also reports frame completion and framing
// errors.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   frame_start  one-cycle pulse, start of a new frame
//   pix_valid    pix_in is valid this cycle
//   pix_in       incoming pixel
//   lb_rst       clear to the line buffers (combinational, = frame_start)
//   lb_wr_en     write enable into the line-buffer chain (combinational)
//   lb_din       data into the line-buffer chain (= pix_in)
//   win_valid    registered pulse, a 3x3 window is complete
//   win_col      registered centre column of that window
//   win_row      registered centre row of that window
//   frame_done   one-cycle pulse, the last pixel of the frame was accepted
//   frame_err    one-cycle pulse, frame_start arrived in the middle of a frame
//   busy         high while priming or streaming
// ---------------------------------------------------------------------------
module linebuf_window_ctrl #(
    parameter int Width      = 12,
    parameter int IMG_width  = 640,
    parameter int IMG_height = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic [Width-1:0] pix_in,
    output logic             lb_rst,
    output logic             lb_wr_en,
    output logic [Width-1:0] lb_din,
    output logic             win_valid,
    output logic [9:0]       win_col,
    output logic [9:0]       win_row,
    output logic             frame_done,
    output logic             frame_err,
    output logic             busy
);

    localparam logic [9:0] COL_LAST = 10'(IMG_width - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_height - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_reg;
    logic [9:0] col_reg;
    logic [9:0] row_reg;
    logic       win_valid_reg;
    logic [9:0] win_col_reg;
    logic [9:0] win_row_reg;
    logic       frame_done_reg;
    logic       frame_err_reg;

    logic in_frame;
    logic accept;
    logic col_last;
    logic row_last;

    assign in_frame = (state_reg == PRIME) || (state_reg == STREAM);

    // frame_start always wins over a pixel arriving in the same cycle.
    assign accept   = pix_valid && !frame_start && in_frame;
    assign col_last = (col_reg == COL_LAST);
    assign row_last = (row_reg == ROW_LAST);

    assign lb_rst     = frame_start;
    assign lb_wr_en   = accept;
    assign lb_din     = pix_in;
    assign busy       = in_frame;
    assign win_valid  = win_valid_reg;
    assign win_col    = win_col_reg;
    assign win_row    = win_row_reg;
    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            col_reg        <= '0;
            row_reg        <= '0;
            win_valid_reg  <= 1'b0;
            win_col_reg    <= '0;
            win_row_reg    <= '0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            // Pulse outputs default low; coordinates hold their last value.
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;

            if (frame_start) begin
                state_reg     <= PRIME;
                col_reg       <= '0;
                row_reg       <= '0;
                // A restart is only an error if a frame was in progress.
                frame_err_reg <= in_frame;
            end else begin
                case (state_reg)
                    IDLE: begin
                    end

                    PRIME: begin
                        if (accept) begin
                            if (col_last) begin
                                col_reg <= '0;
                                row_reg <= row_reg + 10'd1;
                                // Two full lines are now in the buffers.
                                if (row_reg == 10'd1) begin
                                    state_reg <= STREAM;
                                end
                            end else begin
                                col_reg <= col_reg + 10'd1;
                            end
                        end
                    end

                    STREAM: begin
                        if (accept) begin
                            // The incoming pixel is the bottom-right corner of
                            // the window, so the centre is one up and one left.
                            // Columns 0 and 1 would give border windows.
                            if (col_reg >= 10'd2) begin
                                win_valid_reg <= 1'b1;
                                win_col_reg   <= col_reg - 10'd1;
                                win_row_reg   <= row_reg - 10'd1;
                            end
                            if (col_last && row_last) begin
                                col_reg        <= '0;
                                row_reg        <= '0;
                                state_reg      <= DONE;
                                frame_done_reg <= 1'b1;
                            end else if (col_last) begin
                                col_reg <= '0;
                                row_reg <= row_reg + 10'd1;
                            end else begin
                                col_reg <= col_reg + 10'd1;
                            end
                        end
                    end

                    DONE: begin
                        state_reg <= IDLE;
                    end

                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
